// File: rtl/qea_host_loader.sv
`timescale 1ns/1ps
// qea_host_loader
//   Host-side sequencer in front of QEA. One job runs in this order:
//     1. stream i_ins_num gate-context words from the host into CTX RAM
//     2. initialise STATE RAM to |0...0>
//     3. pulse o_qea_start, then count cycles until QEA reports completion
//     4. read the final state back word by word and stream it to the host
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_cmd_start, i_abort            job start (IDLE only), abort to IDLE
//   i_qbit_num, i_ins_num           job parameters, latched at i_cmd_start
//   s_ctx_valid/ready/data          host ctx-word stream
//   o_qea_start, o_qbit_num         QEA start pulse and qubit count
//   o_ctx_en/wea/addr/data          CTX RAM write port
//   o_state_ena/wea/addra/dina      STATE RAM port (init writes, readout reads)
//   i_qea_complete                  QEA done level
//   i_qea_state_dout                STATE RAM read data
//   m_state_valid/ready/data/last   host readout stream
//   o_busy, o_done, o_err           status: not idle, job end pulse, reject pulse
//   o_exec_cycles                   cycles from the start pulse to the complete-seen cycle
module qea_host_loader #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int RD_LATENCY              = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_cmd_start,
  input  logic                                 i_abort,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num,
  input  logic                                 s_ctx_valid,
  output logic                                 s_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   s_ctx_data,
  output logic                                 o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qbit_num,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic                                 o_state_ena,
  output logic                                 o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  input  logic                                 i_qea_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout,
  output logic                                 m_state_valid,
  input  logic                                 m_state_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   m_state_data,
  output logic                                 m_state_last,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic [31:0]                          o_exec_cycles
);

  localparam int WORD_W = PE_NUM * STATE_DATA_WIDTH;
  localparam int LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [GATE_CONTEXT_ADDR_WIDTH:0] CTX_DEPTH = {1'b1, {GATE_CONTEXT_ADDR_WIDTH{1'b0}}};
  localparam logic [GATE_CONTEXT_ADDR_WIDTH:0] INS_ONE   = (GATE_CONTEXT_ADDR_WIDTH+1)'(1);
  localparam logic [MAX_QBIT_WIDTH-1:0]        QBIT_MIN  = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  localparam logic [MAX_QBIT_WIDTH-1:0]        QBIT_MAX  = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);
  localparam logic [STATE_ADDR_WIDTH:0]        WORD_ONE  = (STATE_ADDR_WIDTH+1)'(1);
  localparam logic [LAT_W-1:0]                 WAIT_LAST = LAT_W'(RD_LATENCY - 1);

  // Amplitude 1.0 + 0i, real part in the upper half of the complex word.
  localparam logic [DATA_WIDTH-1:0]       ONE_RE    = DATA_WIDTH'(1) << NUM_FRAC_BIT;
  localparam logic [STATE_DATA_WIDTH-1:0] ONE_STATE = {ONE_RE, {DATA_WIDTH{1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_CTX_LOAD, S_ST_INIT, S_START, S_RUN,
    S_RD_ISSUE, S_RD_WAIT, S_RD_OUT, S_DONE
  } state_t;

  state_t                               state_reg, state_next;
  logic [MAX_QBIT_WIDTH-1:0]            qbit_num_reg;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ins_m1_reg;    // index of the last ctx beat
  logic [STATE_ADDR_WIDTH-1:0]          words_m1_reg;  // index of the last state word
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_cnt_reg;
  logic                                 ctx_en_reg;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_addr_reg;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   ctx_data_reg;
  logic [STATE_ADDR_WIDTH-1:0]          word_cnt_reg;  // init address, then readout index j
  logic [LAT_W-1:0]                     wait_cnt_reg;
  logic [WORD_W-1:0]                    rd_data_reg;
  logic [31:0]                          exec_cnt_reg;
  logic                                 err_reg;

  logic                                 cmd_bad;
  logic                                 abort_hit;
  logic [STATE_ADDR_WIDTH:0]            words_w;
  logic [WORD_W-1:0]                    init_word;

  assign cmd_bad = (i_ins_num == '0) || (i_ins_num > CTX_DEPTH) ||
                   (i_qbit_num <= QBIT_MIN) || (i_qbit_num > QBIT_MAX);
  // Only meaningful for accepted commands, where the shift stays within range.
  assign words_w   = WORD_ONE << (i_qbit_num - QBIT_MIN);
  assign abort_hit = i_abort && (state_reg != S_IDLE);

  // Word 0 of |0...0>: 1.0 in the most significant lane, zero elsewhere.
  generate
    for (genvar gi = 0; gi < PE_NUM; gi++) begin : g_init_lane
      if (gi == PE_NUM - 1) begin : g_one
        assign init_word[gi*STATE_DATA_WIDTH +: STATE_DATA_WIDTH] = ONE_STATE;
      end else begin : g_zero
        assign init_word[gi*STATE_DATA_WIDTH +: STATE_DATA_WIDTH] = '0;
      end
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    s_ctx_ready   = 1'b0;
    o_qea_start   = 1'b0;
    o_state_ena   = 1'b0;
    o_state_wea   = 1'b0;
    o_state_addra = '0;
    o_state_dina  = '0;
    m_state_valid = 1'b0;
    m_state_last  = 1'b0;
    o_done        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (i_cmd_start && !cmd_bad) state_next = S_CTX_LOAD;
      end
      S_CTX_LOAD: begin
        s_ctx_ready = 1'b1;
        if (s_ctx_valid && (ctx_cnt_reg == ins_m1_reg)) state_next = S_ST_INIT;
      end
      S_ST_INIT: begin
        o_state_ena   = 1'b1;
        o_state_wea   = 1'b1;
        o_state_addra = word_cnt_reg;
        o_state_dina  = (word_cnt_reg == '0) ? init_word : '0;
        if (word_cnt_reg == words_m1_reg) state_next = S_START;
      end
      S_START: begin
        o_qea_start = 1'b1;
        state_next  = S_RUN;
      end
      S_RUN: begin
        if (i_qea_complete) state_next = S_RD_ISSUE;
      end
      S_RD_ISSUE: begin
        o_state_ena   = 1'b1;
        o_state_addra = word_cnt_reg;
        state_next    = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        o_state_addra = word_cnt_reg;
        if (wait_cnt_reg == WAIT_LAST) state_next = S_RD_OUT;
      end
      S_RD_OUT: begin
        m_state_valid = 1'b1;
        m_state_last  = (word_cnt_reg == words_m1_reg);
        if (m_state_ready) state_next = m_state_last ? S_DONE : S_RD_ISSUE;
      end
      S_DONE: begin
        o_done     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // Abort wins: no handshake may complete in the abort cycle, so no beat
    // or readout word is consumed and then silently dropped.
    if (abort_hit) begin
      state_next    = S_IDLE;
      s_ctx_ready   = 1'b0;
      m_state_valid = 1'b0;
      m_state_last  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      qbit_num_reg <= '0;
      ins_m1_reg   <= '0;
      words_m1_reg <= '0;
      ctx_cnt_reg  <= '0;
      ctx_en_reg   <= 1'b0;
      ctx_addr_reg <= '0;
      ctx_data_reg <= '0;
      word_cnt_reg <= '0;
      wait_cnt_reg <= '0;
      rd_data_reg  <= '0;
      exec_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg  <= state_next;
      err_reg    <= (state_reg == S_IDLE) && i_cmd_start && cmd_bad;
      ctx_en_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (i_cmd_start && !cmd_bad) begin
            qbit_num_reg <= i_qbit_num;
            ins_m1_reg   <= GATE_CONTEXT_ADDR_WIDTH'(i_ins_num - INS_ONE);
            words_m1_reg <= STATE_ADDR_WIDTH'(words_w - WORD_ONE);
            ctx_cnt_reg  <= '0;
            word_cnt_reg <= '0;
            exec_cnt_reg <= '0;
          end
        end
        S_CTX_LOAD: begin
          // Write is registered: beat k lands in CTX RAM the cycle after it is accepted.
          if (s_ctx_valid && s_ctx_ready) begin
            ctx_en_reg   <= 1'b1;
            ctx_addr_reg <= ctx_cnt_reg;
            ctx_data_reg <= s_ctx_data;
            ctx_cnt_reg  <= ctx_cnt_reg + 1'b1;
          end
        end
        S_ST_INIT: begin
          word_cnt_reg <= (word_cnt_reg == words_m1_reg) ? '0 : word_cnt_reg + 1'b1;
        end
        S_START: begin
          exec_cnt_reg <= 32'd1;
        end
        S_RUN: begin
          // Counts the complete-seen cycle too, then stops because RUN is left.
          if (exec_cnt_reg != '1) exec_cnt_reg <= exec_cnt_reg + 32'd1;
        end
        S_RD_ISSUE: begin
          wait_cnt_reg <= '0;
        end
        S_RD_WAIT: begin
          wait_cnt_reg <= wait_cnt_reg + 1'b1;
          if (state_next == S_RD_OUT) rd_data_reg <= i_qea_state_dout;
        end
        S_RD_OUT: begin
          if (m_state_valid && m_state_ready) word_cnt_reg <= word_cnt_reg + 1'b1;
        end
        default: ;
      endcase
      if (abort_hit) begin
        ctx_en_reg   <= 1'b0;
        ctx_cnt_reg  <= '0;
        word_cnt_reg <= '0;
        wait_cnt_reg <= '0;
      end
    end
  end

  assign o_qbit_num    = qbit_num_reg;
  assign o_ctx_en      = ctx_en_reg;
  assign o_ctx_wea     = ctx_en_reg;
  assign o_ctx_addr    = ctx_addr_reg;
  assign o_ctx_data    = ctx_data_reg;
  assign m_state_data  = rd_data_reg;
  assign o_busy        = (state_reg != S_IDLE);
  assign o_err         = err_reg;
  assign o_exec_cycles = exec_cnt_reg;

endmodule

// File: tb/tb_qea_host_loader.sv
`timescale 1ns/1ps
// Scoreboard bench for qea_host_loader: stimulus pushes expected RAM writes,
// start pulses, readout words and job ends into queues; a negedge monitor pops
// and compares whenever the DUT presents the corresponding event.
module tb_qea_host_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_cmd_start, i_abort;
  logic [5:0]   i_qbit_num;
  logic [16:0]  i_ins_num;
  logic         s_ctx_valid, s_ctx_ready;
  logic [63:0]  s_ctx_data;
  logic         o_qea_start;
  logic [5:0]   o_qbit_num;
  logic         o_ctx_en, o_ctx_wea;
  logic [15:0]  o_ctx_addr;
  logic [63:0]  o_ctx_data;
  logic         o_state_ena, o_state_wea;
  logic [15:0]  o_state_addra;
  logic [255:0] o_state_dina;
  logic         i_qea_complete;
  logic [255:0] i_qea_state_dout;
  logic         m_state_valid, m_state_ready, m_state_last;
  logic [255:0] m_state_data;
  logic         o_busy, o_done, o_err;
  logic [31:0]  o_exec_cycles;

  always #5 clk = ~clk;

  qea_host_loader dut (
    .clk(clk), .rst_n(rst_n), .i_cmd_start(i_cmd_start), .i_abort(i_abort),
    .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
    .s_ctx_valid(s_ctx_valid), .s_ctx_ready(s_ctx_ready), .s_ctx_data(s_ctx_data),
    .o_qea_start(o_qea_start), .o_qbit_num(o_qbit_num),
    .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
    .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
    .o_state_dina(o_state_dina), .i_qea_complete(i_qea_complete),
    .i_qea_state_dout(i_qea_state_dout),
    .m_state_valid(m_state_valid), .m_state_ready(m_state_ready),
    .m_state_data(m_state_data), .m_state_last(m_state_last),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_exec_cycles(o_exec_cycles)
  );

  typedef struct packed { logic [15:0] addr; logic [255:0] data; } wr_t;
  typedef struct packed { logic last; logic [255:0] data; } rd_t;

  wr_t         ctx_q[$];
  wr_t         sw_q[$];
  rd_t         rd_q[$];
  logic [31:0] done_q[$];
  logic [5:0]  start_q[$];
  int          err_q[$];

  int checks = 0;
  int fails  = 0;
  int job_seed = 0;

  localparam logic [255:0] INIT_WORD = {64'h40000000_00000000, 192'd0};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    fails++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  function automatic logic [255:0] pat(input int seed, input int j);
    logic [31:0] w;
    w = {8'hA5, 8'(seed), 8'h5A, 8'(j)};
    return {8{w}};
  endfunction

  function automatic logic [63:0] ctxd(input int seed, input int k);
    return {32'hC0DE0000, 8'h00, 8'(seed), 8'h00, 8'(k)};
  endfunction

  // STATE RAM model, one-cycle read latency. QEA's result is modelled by
  // overwriting the array with a per-job pattern at the start pulse.
  logic [255:0] mem [0:15];
  always @(posedge clk) begin
    if (o_state_ena && o_state_wea) mem[o_state_addra[3:0]] <= o_state_dina;
    if (o_state_ena && !o_state_wea) i_qea_state_dout <= mem[o_state_addra[3:0]];
    if (o_qea_start) for (int i = 0; i < 16; i++) mem[i] <= pat(job_seed, i);
  end

  // QEA completion model: complete rises 10 cycles after the start pulse.
  initial begin
    i_qea_complete = 1'b0;
    forever begin
      @(negedge clk);
      if (o_qea_start) begin
        i_qea_complete = 1'b0;
        repeat (10) @(posedge clk);
        #1 i_qea_complete = 1'b1;
      end
    end
  end

  // Monitor
  logic         hold_prev = 1'b0;
  logic [255:0] hold_data = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_prev) begin
        chk("hold_valid", 256'(m_state_valid), 256'd1);
        chk("hold_data", m_state_data, hold_data);
      end
      hold_prev <= m_state_valid && !m_state_ready;
      hold_data <= m_state_data;
      if (o_ctx_en) begin
        if (ctx_q.size() == 0) unexpected("ctx_write_extra");
        else begin
          chk("ctx_addr", 256'(o_ctx_addr), 256'(ctx_q[0].addr));
          chk("ctx_data", 256'(o_ctx_data), ctx_q[0].data);
          chk("ctx_wea", 256'(o_ctx_wea), 256'd1);
          $display("ctx write addr=%0d data=%h", o_ctx_addr, o_ctx_data);
          void'(ctx_q.pop_front());
        end
      end
      if (o_state_ena && o_state_wea) begin
        if (sw_q.size() == 0) unexpected("state_write_extra");
        else begin
          chk("st_addr", 256'(o_state_addra), 256'(sw_q[0].addr));
          chk("st_data", o_state_dina, sw_q[0].data);
          $display("state write addr=%0d", o_state_addra);
          void'(sw_q.pop_front());
        end
      end
      if (m_state_valid && m_state_ready) begin
        if (rd_q.size() == 0) unexpected("readout_extra");
        else begin
          chk("rd_data", m_state_data, rd_q[0].data);
          chk("rd_last", 256'(m_state_last), 256'(rd_q[0].last));
          $display("readout word last=%0d data=%h", m_state_last, m_state_data[31:0]);
          void'(rd_q.pop_front());
        end
      end
      if (o_qea_start) begin
        if (start_q.size() == 0) unexpected("start_extra");
        else begin
          chk("start_qbit", 256'(o_qbit_num), 256'(start_q[0]));
          $display("qea start qbit=%0d", o_qbit_num);
          void'(start_q.pop_front());
        end
      end
      if (o_done) begin
        if (done_q.size() == 0) unexpected("done_extra");
        else begin
          chk("exec_cycles", 256'(o_exec_cycles), 256'(done_q[0]));
          $display("job done exec_cycles=%0d", o_exec_cycles);
          void'(done_q.pop_front());
        end
      end
      if (o_err) begin
        if (err_q.size() == 0) unexpected("err_extra");
        else begin
          $display("command rejected");
          void'(err_q.pop_front());
        end
      end
    end else begin
      hold_prev <= 1'b0;
    end
  end

  task automatic check_all_zero(input string name);
    chk({name, "_ctl"}, 256'({o_busy, o_qea_start, o_ctx_en, o_ctx_wea, o_state_ena, o_state_wea,
                               s_ctx_ready, m_state_valid, m_state_last, o_done, o_err}), 256'd0);
    chk({name, "_exec"}, 256'(o_exec_cycles), 256'd0);
    chk({name, "_qbit"}, 256'(o_qbit_num), 256'd0);
    chk({name, "_rdata"}, m_state_data, 256'd0);
    chk({name, "_addr"}, 256'({o_ctx_addr, o_state_addra}), 256'd0);
  endtask

  // mode 0: full job; mode 1: abort in ST_INIT; mode 2: reset during RUN.
  // Entered and left at posedge+1.
  task automatic run_job(input int q, input int ins, input bit toggle, input bit stall,
                         input int seed, input int mode);
    int  w, k, cyc, hs, stall_left;
    bit  hsk, gap, done_seen;
    w = 1 << (q - 2);
    for (int i = 0; i < ins; i++) ctx_q.push_back('{addr: 16'(i), data: 256'(ctxd(seed, i))});
    if (mode == 1) sw_q.push_back('{addr: 16'd0, data: INIT_WORD});
    else for (int i = 0; i < w; i++) sw_q.push_back('{addr: 16'(i), data: (i == 0) ? INIT_WORD : 256'd0});
    if (mode != 1) start_q.push_back(6'(q));
    if (mode == 0) begin
      for (int j = 0; j < w; j++) rd_q.push_back('{last: (j == w - 1), data: pat(seed, j)});
      done_q.push_back(32'd11);
    end
    job_seed = seed;
    i_qbit_num = 6'(q); i_ins_num = 17'(ins); i_cmd_start = 1'b1;
    @(posedge clk); #1;
    i_cmd_start = 1'b0;
    chk("busy_after_cmd", 256'(o_busy), 256'd1);
    chk("exec_cleared", 256'(o_exec_cycles), 256'd0);
    chk("qbit_latched", 256'(o_qbit_num), 256'(q));
    k = 0; cyc = 0; gap = 1'b0;
    while (k < ins && cyc < 500) begin
      s_ctx_valid = !gap;
      s_ctx_data  = ctxd(seed, k);
      @(negedge clk);
      hsk = s_ctx_valid && s_ctx_ready;
      @(posedge clk); #1;
      cyc++;
      if (hsk) begin k++; gap = toggle; end else gap = 1'b0;
    end
    s_ctx_valid = 1'b0;
    if (k < ins) chk("ctx_timeout", 256'(k), 256'(ins));
    if (mode == 1) begin
      cyc = 0;
      while (!o_state_ena && cyc < 100) begin @(posedge clk); #1; cyc++; end
      chk("init_reached", 256'(o_state_ena), 256'd1);
      i_abort = 1'b1;
      @(posedge clk); #1;
      i_abort = 1'b0;
      chk("abort_idle", 256'({o_busy, o_state_ena, o_ctx_en, m_state_valid, s_ctx_ready, o_qea_start}), 256'd0);
      repeat (3) @(posedge clk); #1;
      chk("abort_stays_idle", 256'(o_busy), 256'd0);
    end else if (mode == 2) begin
      cyc = 0;
      while (!o_qea_start && cyc < 100) begin @(posedge clk); #1; cyc++; end
      chk("start_reached", 256'(o_qea_start), 256'd1);
      repeat (3) @(posedge clk); #1;
      chk("in_run_busy", 256'(o_busy), 256'd1);
      rst_n = 1'b0;
      #1;
      check_all_zero("reset_in_run");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk); #1;
    end else begin
      cyc = 0; hs = 0; done_seen = 1'b0; stall_left = stall ? 5 : 0;
      while (!done_seen && cyc < 2000) begin
        if (stall && hs == 2 && stall_left > 0) begin m_state_ready = 1'b0; stall_left--; end
        else m_state_ready = 1'b1;
        @(negedge clk);
        if (m_state_valid && m_state_ready) hs++;
        if (o_done) done_seen = 1'b1;
        @(posedge clk); #1;
        cyc++;
      end
      m_state_ready = 1'b1;
      chk("job_done_seen", 256'(done_seen), 256'd1);
      chk("readout_count", 256'(hs), 256'(w));
      chk("idle_after_done", 256'(o_busy), 256'd0);
      chk("exec_held", 256'(o_exec_cycles), 256'd11);
      repeat (2) @(posedge clk); #1;
    end
  endtask

  task automatic reject(input int q, input int ins);
    err_q.push_back(1);
    i_qbit_num = 6'(q); i_ins_num = 17'(ins); i_cmd_start = 1'b1;
    @(posedge clk); #1;
    i_cmd_start = 1'b0;
    chk("reject_busy", 256'(o_busy), 256'd0);
    chk("reject_err", 256'(o_err), 256'd1);
    @(posedge clk); #1;
    chk("reject_err_pulse", 256'({o_busy, o_err, o_ctx_en, o_state_ena}), 256'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_cmd_start = 1'b0; i_abort = 1'b0; i_qbit_num = '0; i_ins_num = '0;
    s_ctx_valid = 1'b0; s_ctx_data = '0; m_state_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(4, 3, 1'b0, 1'b0, 1, 0);   // back-to-back ctx beats, 4 state words
    run_job(5, 5, 1'b1, 1'b1, 2, 0);   // toggling valid, readout stall, 8 words
    reject(4, 0);                       // ins_num == 0
    reject(2, 3);                       // qbit_num <= PE_NUM_WIDTH
    reject(19, 3);                      // qbit_num too large
    reject(4, 65537);                   // ins_num beyond CTX RAM depth
    run_job(4, 2, 1'b0, 1'b0, 3, 1);   // abort during state init
    run_job(4, 3, 1'b0, 1'b0, 4, 0);   // fresh job after abort
    run_job(4, 2, 1'b0, 1'b0, 5, 2);   // reset during RUN
    run_job(3, 1, 1'b1, 1'b0, 6, 0);   // fresh job after reset, 2 words

    repeat (3) @(posedge clk); #1;
    chk("ctx_q_empty", 256'(ctx_q.size()), 256'd0);
    chk("sw_q_empty", 256'(sw_q.size()), 256'd0);
    chk("rd_q_empty", 256'(rd_q.size()), 256'd0);
    chk("start_q_empty", 256'(start_q.size()), 256'd0);
    chk("done_q_empty", 256'(done_q.size()), 256'd0);
    chk("err_q_empty", 256'(err_q.size()), 256'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
